// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver FSM state type.
// The transmitter uses the same frame constants so both ends agree on the format.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser for an asynchronous single-bit input.
// Every stage is preset to RESET_VAL on reset. For a UART line this value is 1,
// so the line reads as idle while the design comes out of reset.
module uart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clc,
  input  logic res,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clc) begin
    if (res) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver. Each frame is 1 start bit, 8 data bits LSB first, and one or
// more stop bits. Each bit is sampled at its midpoint by a clock-count timer.
//
// Output protocol: there is no ready signal and no buffering.
// - priznak_end_receiver is high for exactly one cycle, and in that cycle
//   word_receiver carries the new byte. The consumer must capture it then.
// - word_receiver holds the byte until the next good frame.
// - frame_error is high for one cycle when a stop bit is sampled low.
// - priznak_end_receiver and frame_error are never high in the same cycle.
// - The FSM state is available as the internal signal `state` for checkers.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clc,
  input  logic                 res,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] word_receiver,
  output logic                 priznak_end_receiver,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS);
  localparam int TW = $clog2(CLKS_PER_BIT);

  // Timer compare values. The half period is rounded down (floor).
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t          state,     state_nxt;
  logic [TW-1:0]        timer,     timer_nxt;
  logic [IW-1:0]        idx,       idx_nxt;
  logic [DATA_BITS-1:0] shift,     shift_nxt;
  logic [DATA_BITS-1:0] word_nxt;
  logic                 strobe_nxt;
  logic                 ferr_nxt;

  uart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clc (clc),
    .res (res),
    .d   (RX),
    .q   (rx_s)
  );

  // State, bit timer, shift register and registered outputs.
  always_ff @(posedge clc) begin
    if (res) begin
      state                <= IDLE;
      timer                <= '0;
      idx                  <= '0;
      shift                <= '0;
      word_receiver        <= '0;
      priznak_end_receiver <= 1'b0;
      frame_error          <= 1'b0;
    end else begin
      state                <= state_nxt;
      timer                <= timer_nxt;
      idx                  <= idx_nxt;
      shift                <= shift_nxt;
      word_receiver        <= word_nxt;
      priznak_end_receiver <= strobe_nxt;
      frame_error          <= ferr_nxt;
    end
  end

  // Next-state logic, bit sampling, and output pulse generation.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + TW'(1);
    idx_nxt    = idx;
    shift_nxt  = shift;
    word_nxt   = word_receiver;
    strobe_nxt = 1'b0;
    ferr_nxt   = 1'b0;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        // Check mid-start-bit. A line that is high again was a glitch.
        if (timer == HALF_END) begin
          timer_nxt = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        // Sampling is offset by half a bit from the start check,
        // so every data bit is sampled at its midpoint.
        if (timer == BIT_END) begin
          timer_nxt      = '0;
          shift_nxt[idx] = rx_s;
          idx_nxt        = idx + IW'(1);
          if (idx == LAST_IDX) begin
            state_nxt = STOP;
          end
        end
      end

      STOP: begin
        if (timer == BIT_END) begin
          timer_nxt = '0;
          if (rx_s) begin
            word_nxt   = shift;
            strobe_nxt = 1'b1;
            state_nxt  = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK_WAIT;
          end
        end
      end

      BREAK_WAIT: begin
        // Wait here while the line is held low, so a break does not
        // decode as a stream of 0x00 frames.
        timer_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver with a 16-cycle bit period and a 2-stage synchroniser.
module tb_uart_receiver;

  localparam int C   = 16;
  localparam int S   = 2;
  localparam int H   = C / 2;
  localparam int LAT = S + H + 9 * C + 1;

  logic       clc = 1'b0;
  logic       res;
  logic       RX;
  logic [7:0] word_receiver;
  logic       priznak_end_receiver;
  logic       frame_error;
  logic       busy;

  int         total   = 0;
  int         bad     = 0;
  int         cyc     = 0;
  int         fe_seen = 0;
  int         strobes = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic [7:0] last_word;

  uart_receiver #(
    .CLKS_PER_BIT (C),
    .SYNC_STAGES  (S)
  ) dut (
    .clc                  (clc),
    .res                  (res),
    .RX                   (RX),
    .word_receiver        (word_receiver),
    .priznak_end_receiver (priznak_end_receiver),
    .frame_error          (frame_error),
    .busy                 (busy)
  );

  // Clock and cycle counter.
  always #5 clc = ~clc;
  always @(posedge clc) cyc <= cyc + 1;

  // Advance n cycles and land 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clc);
      #1;
    end
  endtask

  // Drive one frame on RX. A good frame (stop_val=1) pushes its byte and start cycle.
  task automatic send_frame(input logic [7:0] d, input int n_stop, input logic stop_val);
    if (stop_val) begin
      exp_q.push_back(d);
      start_q.push_back(cyc);
      last_word = d;
    end
    RX = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      tick(C);
    end
    RX = stop_val;
    tick(C * n_stop);
  endtask

  // Wait, within a cycle budget, until every expected strobe has arrived.
  task automatic wait_drain();
    for (int i = 0; i < 20 * C; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
      exp_q.delete();
      start_q.delete();
    end
  endtask

  // Scoreboard: check each strobe against the expected queue and the latency.
  initial begin
    logic [7:0] e;
    int st;
    int lat;
    forever begin
      @(posedge clc);
      #1;
      if (priznak_end_receiver) begin
        strobes++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: got=%h required=none", word_receiver);
        end else begin
          e   = exp_q.pop_front();
          st  = start_q.pop_front();
          lat = cyc - st;
          if (word_receiver !== e) begin
            bad++;
            $display("FAIL strobe_data: got=%h required=%h", word_receiver, e);
          end
          total++;
          if (lat < LAT - 1 || lat > LAT + 1) begin
            bad++;
            $display("FAIL latency: got=%0d required=%0d+-1", lat, LAT);
          end
        end
      end
      if (frame_error) begin
        fe_seen++;
        total++;
        if (priznak_end_receiver) begin
          bad++;
          $display("FAIL both_pulses: strobe=1 frame_error=1 required=not both");
        end
      end
    end
  end

  task automatic test_reset();
    res = 1'b1;
    RX  = 1'b1;
    tick(3);
    total += 4;
    if (word_receiver !== 8'h00) begin bad++; $display("FAIL rst_word: got=%h required=00", word_receiver); end
    if (priznak_end_receiver !== 1'b0) begin bad++; $display("FAIL rst_strobe: got=%b required=0", priznak_end_receiver); end
    if (frame_error !== 1'b0) begin bad++; $display("FAIL rst_ferr: got=%b required=0", frame_error); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b required=0", busy); end
    res = 1'b0;
    last_word = 8'h00;
    tick(2 * C);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got=%b required=0", busy); end
  endtask

  task automatic test_single();
    int fe0 = fe_seen;
    int s0  = strobes;
    send_frame(8'hA5, 1, 1'b1);
    wait_drain();
    tick(4);
    total += 3;
    if (strobes - s0 != 1) begin bad++; $display("FAIL single_count: got=%0d required=1", strobes - s0); end
    if (fe_seen != fe0) begin bad++; $display("FAIL single_ferr: got=%0d required=%0d", fe_seen, fe0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got=%b required=0", busy); end
  endtask

  task automatic test_back_to_back();
    int s0 = strobes;
    send_frame(8'h00, 2, 1'b1);
    send_frame(8'hFF, 2, 1'b1);
    send_frame(8'h5A, 2, 1'b1);
    wait_drain();
    total++;
    if (strobes - s0 != 3) begin bad++; $display("FAIL b2b_count: got=%0d required=3", strobes - s0); end
  endtask

  task automatic test_glitch();
    int fe0 = fe_seen;
    int s0  = strobes;
    int busy_cnt = 0;
    RX = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy) busy_cnt++;
      if (i == 4) RX = 1'b1;
    end
    total += 4;
    if (busy_cnt < 1 || busy_cnt > 9) begin bad++; $display("FAIL glitch_busy_len: got=%0d required=1..9", busy_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: got=%b required=0", busy); end
    if (strobes != s0) begin bad++; $display("FAIL glitch_strobe: got=%0d required=%0d", strobes, s0); end
    if (fe_seen != fe0) begin bad++; $display("FAIL glitch_ferr: got=%0d required=%0d", fe_seen, fe0); end
  endtask

  task automatic test_frame_error();
    int fe0 = fe_seen;
    int s0  = strobes;
    send_frame(8'h3C, 1, 1'b0);
    tick(40);
    RX = 1'b1;
    tick(2 * C);
    total += 4;
    if (fe_seen - fe0 != 1) begin bad++; $display("FAIL ferr_count: got=%0d required=1", fe_seen - fe0); end
    if (word_receiver !== last_word) begin bad++; $display("FAIL ferr_word_hold: got=%h required=%h", word_receiver, last_word); end
    if (strobes != s0) begin bad++; $display("FAIL ferr_strobe: got=%0d required=%0d", strobes, s0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy: got=%b required=0", busy); end
    send_frame(8'h81, 1, 1'b1);
    wait_drain();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hC3;
    int s0 = strobes;
    RX = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      RX = d[i];
      tick(C);
    end
    RX = d[3];
    tick(H);
    res = 1'b1;
    tick(2);
    total += 4;
    if (word_receiver !== 8'h00) begin bad++; $display("FAIL mid_rst_word: got=%h required=00", word_receiver); end
    if (priznak_end_receiver !== 1'b0) begin bad++; $display("FAIL mid_rst_strobe: got=%b required=0", priznak_end_receiver); end
    if (frame_error !== 1'b0) begin bad++; $display("FAIL mid_rst_ferr: got=%b required=0", frame_error); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got=%b required=0", busy); end
    RX  = 1'b1;
    res = 1'b0;
    last_word = 8'h00;
    tick(3 * C);
    total++;
    if (strobes != s0) begin bad++; $display("FAIL aborted_strobe: got=%0d required=%0d", strobes, s0); end
    send_frame(8'h12, 1, 1'b1);
    wait_drain();
  endtask

  task automatic test_loopback();
    int fe0 = fe_seen;
    int s0  = strobes;
    for (int b = 0; b < 256; b++) begin
      send_frame(8'(b), 2, 1'b1);
      tick($urandom_range(0, 3));
    end
    wait_drain();
    total += 2;
    if (strobes - s0 != 256) begin bad++; $display("FAIL loop_count: got=%0d required=256", strobes - s0); end
    if (fe_seen != fe0) begin bad++; $display("FAIL loop_ferr: got=%0d required=%0d", fe_seen - fe0, 0); end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_loopback();
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
